controlador_exibicao: RTL and testbench

CONTROLADOR_EXIBICAO -- requirements
Module: controlador_exibicao

---
 rtl/controlador_exibicao_if.sv | 31 +++
 rtl/controlador_exibicao.sv | 121 ++++++++++++
 tb/tb_controlador_exibicao.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/controlador_exibicao_if.sv
`default_nettype none
// ============================================================================
// Module      : controlador_exibicao_if
// Description : Bus bundle between the sequence display controller and its
//               surroundings (start request, round index, sequence ROM port,
//               LED pattern and status/debug outputs).
//               master : drives iniciar, rodada, memoria; observes the rest
//               slave  : the controller itself
// Revision    : 1.0 - initial release
// ============================================================================
interface controlador_exibicao_if;
   logic       iniciar;       // level request to start a run
   logic [3:0] rodada;        // index of the last item to show
   logic [3:0] memoria;       // ROM data at address endereco
   logic [3:0] endereco;      // ROM address
   logic [3:0] leds;          // LED pattern being shown
   logic       ocupado;       // run in progress
   logic       fim_exibicao;  // one-cycle end-of-run pulse
   logic [3:0] db_estado;     // encoded FSM state for debug

   modport master (
      output iniciar, rodada, memoria,
      input  endereco, leds, ocupado, fim_exibicao, db_estado
   );

   modport slave (
      input  iniciar, rodada, memoria,
      output endereco, leds, ocupado, fim_exibicao, db_estado
   );
endinterface
`default_nettype wire

// File: rtl/controlador_exibicao.sv
`default_nettype none
// ============================================================================
// Module      : controlador_exibicao
// Description : Plays back a stored sequence on four LEDs. On a start request
//               it walks the sequence ROM from address 0 up to the latched
//               round index, lighting each item for TEMPO_ACESO cycles and
//               then leaving a TEMPO_APAGADO-cycle dark gap.
// Ports       : clock  - system clock, rising edge
//               reset  - synchronous, active-high
//               bus    - controlador_exibicao_if.slave (iniciar, rodada,
//                        memoria in; endereco, leds, ocupado, fim_exibicao,
//                        db_estado out)
// Revision    : 1.0 - initial release
// ============================================================================
module controlador_exibicao #(
   parameter int TEMPO_ACESO   = 4,
   parameter int TEMPO_APAGADO = 2
) (
   input  wire logic              clock,
   input  wire logic              reset,
   controlador_exibicao_if.slave  bus
);

   typedef enum logic [3:0] {
      INICIAL = 4'd0,
      CARREGA = 4'd1,
      ACESO   = 4'd2,
      APAGADO = 4'd3,
      FIM     = 4'd4
   } estado_t;

   // Terminal timer values: each phase ends on the cycle the timer hits these.
   localparam logic [15:0] c_ult_aceso   = 16'(TEMPO_ACESO - 1);
   localparam logic [15:0] c_ult_apagado = 16'(TEMPO_APAGADO - 1);

   estado_t     r_estado;
   logic [3:0]  r_endereco;
   logic [15:0] r_timer;
   logic [3:0]  r_leds;
   logic [3:0]  r_rodada;

   estado_t     w_prox;
   logic [3:0]  w_endereco;
   logic [15:0] w_timer;
   logic [3:0]  w_leds;
   logic [3:0]  w_rodada;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_estado   <= INICIAL;
         r_endereco <= 4'd0;
         r_timer    <= 16'd0;
         r_leds     <= 4'd0;
         r_rodada   <= 4'd0;
      end else begin
         r_estado   <= w_prox;
         r_endereco <= w_endereco;
         r_timer    <= w_timer;
         r_leds     <= w_leds;
         r_rodada   <= w_rodada;
      end
   end

   always_comb begin
      w_prox     = r_estado;
      w_endereco = r_endereco;
      w_timer    = r_timer;
      w_leds     = r_leds;
      w_rodada   = r_rodada;
      case (r_estado)
         INICIAL: begin
            // Round index is captured only here, so later changes on rodada
            // cannot stretch or shorten a run already in progress.
            if (bus.iniciar) begin
               w_rodada   = bus.rodada;
               w_endereco = 4'd0;
               w_prox     = CARREGA;
            end
         end
         CARREGA: begin
            w_leds  = bus.memoria;
            w_timer = 16'd0;
            w_prox  = ACESO;
         end
         ACESO: begin
            if (r_timer == c_ult_aceso) begin
               w_timer = 16'd0;
               w_prox  = APAGADO;
            end else begin
               w_timer = r_timer + 16'd1;
            end
         end
         APAGADO: begin
            if (r_timer == c_ult_apagado) begin
               w_timer = 16'd0;
               // Stop on the last item rather than incrementing, so the
               // address never wraps past 15.
               if (r_endereco == r_rodada) begin
                  w_prox = FIM;
               end else begin
                  w_endereco = r_endereco + 4'd1;
                  w_prox     = CARREGA;
               end
            end else begin
               w_timer = r_timer + 16'd1;
            end
         end
         FIM:     w_prox = INICIAL;
         default: w_prox = INICIAL;
      endcase
   end

   // Outputs are decodes of registered state only.
   assign bus.endereco     = r_endereco;
   assign bus.leds         = (r_estado == ACESO) ? r_leds : 4'd0;
   assign bus.ocupado      = (r_estado != INICIAL);
   assign bus.fim_exibicao = (r_estado == FIM);
   assign bus.db_estado    = r_estado;

endmodule
`default_nettype wire

// File: tb/tb_controlador_exibicao.sv
`default_nettype none
// ============================================================================
// Module      : tb_controlador_exibicao
// Description : Directed self-checking bench for controlador_exibicao. One
//               instance uses default timing, a second uses 1/1 timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_controlador_exibicao;

   logic clock;
   logic reset;

   controlador_exibicao_if bus_a ();
   controlador_exibicao_if bus_b ();

   controlador_exibicao u_dut_a (
      .clock (clock),
      .reset (reset),
      .bus   (bus_a.slave)
   );

   controlador_exibicao #(
      .TEMPO_ACESO   (1),
      .TEMPO_APAGADO (1)
   ) u_dut_b (
      .clock (clock),
      .reset (reset),
      .bus   (bus_b.slave)
   );

   localparam logic [3:0] ROM [16] = '{
      4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h5, 4'h6, 4'h9,
      4'hA, 4'hC, 4'h7, 4'hB, 4'hD, 4'hE, 4'hF, 4'h1
   };

   assign bus_a.memoria = ROM[bus_a.endereco];
   assign bus_b.memoria = ROM[bus_b.endereco];

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Observation mux: sel picks which instance the check tasks look at.
   logic       sel;
   logic [3:0] o_db, o_leds, o_end;
   logic       o_ocp, o_fim;
   always_comb begin
      o_db   = sel ? bus_b.db_estado    : bus_a.db_estado;
      o_leds = sel ? bus_b.leds         : bus_a.leds;
      o_end  = sel ? bus_b.endereco     : bus_a.endereco;
      o_ocp  = sel ? bus_b.ocupado      : bus_a.ocupado;
      o_fim  = sel ? bus_b.fim_exibicao : bus_a.fim_exibicao;
   end

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int t0     = 0;

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One sequence item: CARREGA cycle, na lit cycles, np dark cycles.
   task automatic item(input logic [3:0] addr, input logic [3:0] pat, input int na, input int np);
      chk("carrega_db", 16'(o_db), 16'd1);
      chk("carrega_leds", 16'(o_leds), 16'd0);
      chk("carrega_end", 16'(o_end), 16'(addr));
      chk("carrega_ocp", 16'(o_ocp), 16'd1);
      tick();
      for (int i = 0; i < na; i++) begin
         chk("aceso_db", 16'(o_db), 16'd2);
         chk("aceso_leds", 16'(o_leds), 16'(pat));
         chk("aceso_fim", 16'(o_fim), 16'd0);
         tick();
      end
      for (int i = 0; i < np; i++) begin
         chk("apagado_db", 16'(o_db), 16'd3);
         chk("apagado_leds", 16'(o_leds), 16'd0);
         tick();
      end
   endtask

   // FIM cycle, its position counted from the start edge, then INICIAL.
   task automatic fim_end(input int exp_cycle);
      chk("fim_db", 16'(o_db), 16'd4);
      chk("fim_pulse", 16'(o_fim), 16'd1);
      chk("fim_ocp", 16'(o_ocp), 16'd1);
      chk("fim_leds", 16'(o_leds), 16'd0);
      chk("fim_cycle", 16'(cyc - t0 + 1), 16'(exp_cycle));
      tick();
      chk("pos_fim_db", 16'(o_db), 16'd0);
      chk("pos_fim_ocp", 16'(o_ocp), 16'd0);
      chk("pos_fim_pulse", 16'(o_fim), 16'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      sel           = 1'b0;
      reset         = 1'b1;
      bus_a.iniciar = 1'b0;
      bus_a.rodada  = 4'd0;
      bus_b.iniciar = 1'b0;
      bus_b.rodada  = 4'd0;
      tick();
      tick();

      // Reset state
      chk("rst_db", 16'(o_db), 16'd0);
      chk("rst_leds", 16'(o_leds), 16'd0);
      chk("rst_ocp", 16'(o_ocp), 16'd0);
      chk("rst_fim", 16'(o_fim), 16'd0);
      chk("rst_end", 16'(o_end), 16'd0);
      reset = 1'b0;
      tick();
      chk("idle_db", 16'(o_db), 16'd0);

      // Single item, default timing
      bus_a.rodada  = 4'd0;
      bus_a.iniciar = 1'b1;
      tick();
      t0 = cyc;
      bus_a.iniciar = 1'b0;
      item(4'd0, 4'h1, 4, 2);
      fim_end(8);

      // Three items 1,2,4
      bus_a.rodada  = 4'd2;
      bus_a.iniciar = 1'b1;
      tick();
      t0 = cyc;
      bus_a.iniciar = 1'b0;
      item(4'd0, 4'h1, 4, 2);
      item(4'd1, 4'h2, 4, 2);
      item(4'd2, 4'h4, 4, 2);
      fim_end(22);

      // Sixteen items, no address wrap
      bus_a.rodada  = 4'd15;
      bus_a.iniciar = 1'b1;
      tick();
      t0 = cyc;
      bus_a.iniciar = 1'b0;
      for (int i = 0; i < 16; i++) item(4'(i), ROM[i], 4, 2);
      chk("fim15_end", 16'(o_end), 16'd15);
      fim_end(113);

      // Reset during second ACESO
      bus_a.rodada  = 4'd2;
      bus_a.iniciar = 1'b1;
      tick();
      bus_a.iniciar = 1'b0;
      item(4'd0, 4'h1, 4, 2);
      chk("mid_carrega_db", 16'(o_db), 16'd1);
      tick();
      chk("mid_aceso_leds", 16'(o_leds), 16'h2);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid_rst_db", 16'(o_db), 16'd0);
      chk("mid_rst_leds", 16'(o_leds), 16'd0);
      chk("mid_rst_ocp", 16'(o_ocp), 16'd0);
      chk("mid_rst_end", 16'(o_end), 16'd0);
      for (int i = 0; i < 10; i++) begin
         chk("mid_rst_nofim", 16'({o_fim, o_db}), 16'd0);
         tick();
      end

      // Reset has priority over iniciar
      bus_a.iniciar = 1'b1;
      reset         = 1'b1;
      tick();
      reset         = 1'b0;
      bus_a.iniciar = 1'b0;
      chk("prio_db", 16'(o_db), 16'd0);
      chk("prio_ocp", 16'(o_ocp), 16'd0);
      tick();
      chk("prio_idle_db", 16'(o_db), 16'd0);

      // Inputs disturbed mid-run; iniciar held through FIM restarts
      bus_a.rodada  = 4'd2;
      bus_a.iniciar = 1'b1;
      tick();
      t0 = cyc;
      bus_a.iniciar = 1'b0;
      bus_a.rodada  = 4'd7;
      item(4'd0, 4'h1, 4, 2);
      bus_a.iniciar = 1'b1;
      item(4'd1, 4'h2, 4, 2);
      bus_a.iniciar = 1'b0;
      item(4'd2, 4'h4, 4, 2);
      bus_a.iniciar = 1'b1;
      fim_end(22);
      tick();
      chk("restart_db", 16'(o_db), 16'd1);
      chk("restart_end", 16'(o_end), 16'd0);
      bus_a.iniciar = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;

      // Fast instance: 1 lit cycle, 1 dark cycle, two items
      sel           = 1'b1;
      tick();
      chk("b_idle_db", 16'(o_db), 16'd0);
      bus_b.rodada  = 4'd1;
      bus_b.iniciar = 1'b1;
      tick();
      t0 = cyc;
      bus_b.iniciar = 1'b0;
      item(4'd0, ROM[0], 1, 1);
      item(4'd1, ROM[1], 1, 1);
      fim_end(7);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
